load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one memory op at a time over a simple req/ack bus.
// Ports: clk/rst, start+is_store/funct3/addr/store_data from execute; busy,
// done, misaligned, mem_rd_data to the pipeline; bus_* to the memory slave.
module load_store_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_store,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] store_data,
    output logic             busy,
    output logic             done,
    output logic             misaligned,
    output logic [WIDTH-1:0] mem_rd_data,
    output logic             bus_req,
    output logic             bus_we,
    output logic [WIDTH-1:0] bus_addr,
    output logic [WIDTH-1:0] bus_wdata,
    output logic [3:0]       bus_be,
    input  logic             bus_ack,
    input  logic [WIDTH-1:0] bus_rdata
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BUS   = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;
    localparam logic [1:0] S_FAULT = 2'd3;

    logic [1:0]       state;
    logic             is_store_q;
    logic [2:0]       funct3_q;
    logic [1:0]       lane_q;
    logic [WIDTH-1:0] addr_q;
    logic [WIDTH-1:0] wdata_q;
    logic [WIDTH-1:0] rd_q;

    logic             illegal;
    logic             misal;
    logic [WIDTH-1:0] wdata_rep;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [WIDTH-1:0] ld_val;

    // Decode of the incoming op, used only in IDLE when start is high.
    always_comb begin
        illegal = 1'b0;
        if (is_store) begin
            illegal = (funct3 >= 3'b011);
        end else begin
            illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
        end
        misal = 1'b0;
        case (funct3[1:0])
            2'b01:   misal = addr[0];
            2'b10:   misal = (addr[1:0] != 2'b00);
            default: misal = 1'b0;
        endcase
    end

    // Replicate narrow store data so every byte lane carries it.
    always_comb begin
        wdata_rep = store_data;
        case (funct3[1:0])
            2'b00:   wdata_rep = {4{store_data[7:0]}};
            2'b01:   wdata_rep = {2{store_data[15:0]}};
            default: wdata_rep = store_data;
        endcase
    end

    always_comb begin
        bus_be = 4'b0000;
        if (state == S_BUS) begin
            case (funct3_q[1:0])
                2'b00:   bus_be = 4'b0001 << lane_q;
                2'b01:   bus_be = lane_q[1] ? 4'b1100 : 4'b0011;
                default: bus_be = 4'b1111;
            endcase
        end
    end

    // Lane select and extension of the returned word.
    always_comb begin
        ld_byte = bus_rdata[7:0];
        case (lane_q)
            2'd0:    ld_byte = bus_rdata[7:0];
            2'd1:    ld_byte = bus_rdata[15:8];
            2'd2:    ld_byte = bus_rdata[23:16];
            default: ld_byte = bus_rdata[31:24];
        endcase
        ld_half = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        ld_val  = bus_rdata;
        case (funct3_q)
            3'b000:  ld_val = {{(WIDTH-8){ld_byte[7]}}, ld_byte};
            3'b001:  ld_val = {{(WIDTH-16){ld_half[15]}}, ld_half};
            3'b100:  ld_val = {{(WIDTH-8){1'b0}}, ld_byte};
            3'b101:  ld_val = {{(WIDTH-16){1'b0}}, ld_half};
            default: ld_val = bus_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            is_store_q <= 1'b0;
            funct3_q   <= 3'b000;
            lane_q     <= 2'b00;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_q       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (illegal || misal) begin
                            state <= S_FAULT;
                        end else begin
                            state      <= S_BUS;
                            is_store_q <= is_store;
                            funct3_q   <= funct3;
                            lane_q     <= addr[1:0];
                            addr_q     <= {addr[WIDTH-1:2], 2'b00};
                            wdata_q    <= wdata_rep;
                        end
                    end
                end
                S_BUS: begin
                    if (bus_ack) begin
                        state <= S_RESP;
                        if (!is_store_q) begin
                            rd_q <= ld_val;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy        = (state != S_IDLE);
    assign done        = (state == S_RESP) || (state == S_FAULT);
    assign misaligned  = (state == S_FAULT);
    assign bus_req     = (state == S_BUS);
    assign bus_we      = (state == S_BUS) && is_store_q;
    assign bus_addr    = addr_q;
    assign bus_wdata   = wdata_q;
    assign mem_rd_data = rd_q;

endmodule
